uart_alu_host: RTL

UART_ALU_HOST -- requirements
Module: uart_alu_host

---
 rtl/uart_alu_host.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_alu_host.sv
// rtl/uart_alu_host.sv - host-side sequencer that ships (a, b, op) to a UART ALU and collects the result byte
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_a, req_b, req_op are captured on acceptance
//   wr_uart, w_data       TX FIFO write strobe and byte; tx_full back-pressures the writes
//   rd_uart, r_data       RX FIFO read strobe and head byte; rx_empty marks no byte available
//   res, res_valid        result byte (held) and a one-cycle pulse marking a new result
//   timeout               one-cycle pulse when a transaction is abandoned in WAIT_RES
//
// Build option: define UART_HOST_TIMEOUT_EN to abandon WAIT_RES after TIMEOUT_CYCLES
// cycles without a result byte. Without it the block waits for the result indefinitely.

module uart_alu_host #(
    parameter int REG_SIZE       = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [REG_SIZE-1:0] req_a,
    input  logic [REG_SIZE-1:0] req_b,
    input  logic [REG_SIZE-1:0] req_op,
    output logic                wr_uart,
    output logic [7:0]          w_data,
    input  logic                tx_full,
    output logic                rd_uart,
    input  logic [7:0]          r_data,
    input  logic                rx_empty,
    output logic [REG_SIZE-1:0] res,
    output logic                res_valid,
    output logic                timeout
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_A   = 3'd1;
    localparam logic [2:0] SEND_B   = 3'd2;
    localparam logic [2:0] SEND_OP  = 3'd3;
    localparam logic [2:0] WAIT_RES = 3'd4;

    // Byte-wide UART path only; any other operand width or a degenerate timeout is a build error.
    if (REG_SIZE != 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_alu_host: REG_SIZE must be 8 and TIMEOUT_CYCLES at least 2");
    end

    logic [2:0]          state;
    logic [REG_SIZE-1:0] a_q;
    logic [REG_SIZE-1:0] b_q;
    logic [REG_SIZE-1:0] op_q;
    logic                tmo_hit;

    assign req_ready = (state == IDLE);

    // Strobes are combinational so a byte moves on the very edge the FIFO can take it.
    // rd_uart is also gated by reset: the state already reads IDLE during reset, and
    // without the gate the idle drain would pop RX bytes while the block is held.
    always_comb begin
        wr_uart = 1'b0;
        w_data  = 8'h00;
        rd_uart = 1'b0;
        case (state)
            SEND_A: begin
                wr_uart = ~tx_full;
                w_data  = a_q;
            end
            SEND_B: begin
                wr_uart = ~tx_full;
                w_data  = b_q;
            end
            SEND_OP: begin
                wr_uart = ~tx_full;
                w_data  = op_q;
            end
            IDLE, WAIT_RES: begin
                // In IDLE this drains stray bytes; in WAIT_RES it fetches the result.
                rd_uart = ~rx_empty & ~reset;
            end
            default: begin
                wr_uart = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        op_q  <= req_op;
                        state <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (wr_uart) state <= SEND_B;
                end
                SEND_B: begin
                    if (wr_uart) state <= SEND_OP;
                end
                SEND_OP: begin
                    if (wr_uart) state <= WAIT_RES;
                end
                WAIT_RES: begin
                    // An available byte wins over an expiring timeout on the same edge.
                    if (rd_uart) begin
                        res       <= r_data;
                        res_valid <= 1'b1;
                        state     <= IDLE;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    // The counter holds the number of WAIT_RES cycles already spent without a byte,
    // so it reads TIMEOUT_CYCLES-1 during the last permitted cycle.
    assign tmo_hit = (state == WAIT_RES) && rx_empty &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= tmo_hit;
            if (state == SEND_OP && wr_uart) begin
                wait_cnt <= '0;
            end else if (state == WAIT_RES && !rd_uart && !tmo_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
